// File: rtl/register_bank_writer_pkg.sv
// Shared constants for the register-bank write side: FSM encodings and
// architecturally special register indices.
package register_bank_writer_pkg;

    // FSM state encodings; two bits so that an illegal encoding exists and
    // can be recovered from.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CLEAR = 2'b01;

    // Architectural register indices.
    localparam logic [4:0] REG_ZERO = 5'd0;   // hard-wired zero
    localparam logic [4:0] REG_SP   = 5'd29;  // stack pointer
    localparam logic [4:0] REG_LAST = 5'd31;  // final register of the sweep

endpackage

// File: rtl/register_bank_writer_write_decoder.sv
// 5-to-32 one-hot write decoder. Bit 0 is never asserted, so register 0 can
// never be written regardless of the address presented.
module write_decoder_5to32
    import register_bank_writer_pkg::*;
(
    input  logic [4:0]  i_addr,
    input  logic        i_en,
    output logic [31:0] o_onehot
);

    // Decode the address into a single write strobe, masking register 0.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end
        o_onehot[REG_ZERO] = 1'b0;
    end

endmodule

// File: rtl/register_bank_writer.sv
// Write side of the MIPS register file: 31 storage registers (reg0 is
// constant zero), a valid/ready write port and a bulk-clear sweep that
// reinitialises registers 1..31 one per cycle.
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
// wr_ready is combinational, high only in IDLE with no clear_req pending;
// a requester that sees wr_ready low must hold wr_valid/wr_addr/wr_data
// stable until it transfers.
module register_bank_writer
    import register_bank_writer_pkg::*;
#(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] SP_INIT     = 32'h7FFF_FFFC
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4:0]                wr_addr,
    input  logic [WORD_LENGTH-1:0]    wr_data,
    input  logic                      clear_req,
    output logic                      busy,
    output logic                      clear_done,
    output logic [32*WORD_LENGTH-1:0] regs_flat,
    output logic [1:0]                dbg_state
);

    logic [1:0]             r_state;
    logic [4:0]             r_cnt;

    logic                   w_in_clear;
    logic                   w_wr_fire;
    logic                   w_dec_en;
    logic [4:0]             w_dec_addr;
    logic [WORD_LENGTH-1:0] w_wr_value;
    logic [WORD_LENGTH-1:0] w_sweep_value;
    logic [31:0]            w_onehot;
    logic                   w_unused_bit0;

    assign w_in_clear    = (r_state == ST_CLEAR);
    assign wr_ready      = (r_state == ST_IDLE) && !clear_req;
    assign w_wr_fire     = wr_valid && wr_ready;
    assign busy          = w_in_clear;
    assign clear_done    = w_in_clear && (r_cnt == REG_LAST);
    assign dbg_state     = r_state;

    // The sweep and the write port share one decoder; state picks the source.
    assign w_sweep_value = (r_cnt == REG_SP) ? SP_INIT : '0;
    assign w_dec_addr    = w_in_clear ? r_cnt : wr_addr;
    assign w_dec_en      = w_in_clear || w_wr_fire;
    assign w_wr_value    = w_in_clear ? w_sweep_value : wr_data;

    write_decoder_5to32 u_decoder (
        .i_addr   (w_dec_addr),
        .i_en     (w_dec_en),
        .o_onehot (w_onehot)
    );

    // Strobe for register 0 is always low and has no storage behind it.
    assign w_unused_bit0 = w_onehot[0];

    // Control FSM and sweep counter; the counter exits at 31 so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= 5'd1;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == REG_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 5'd1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 5'd1;
                end
            endcase
        end
    end

    // Register 0 reads as constant zero.
    assign regs_flat[0 +: WORD_LENGTH] = '0;

    // Storage registers 1..31, each loaded when its decoder strobe fires.
    for (genvar k = 1; k < 32; k++) begin : g_reg
        localparam logic [4:0]             K_IDX   = 5'(k);
        localparam logic [WORD_LENGTH-1:0] RST_VAL = (K_IDX == REG_SP) ? SP_INIT : '0;

        logic [WORD_LENGTH-1:0] r_value;

        // Hold the register value, updating on its write strobe.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_value <= RST_VAL;
            end else if (w_onehot[k]) begin
                r_value <= w_wr_value;
            end
        end

        assign regs_flat[k*WORD_LENGTH +: WORD_LENGTH] = r_value;
    end

endmodule

// File: tb/tb_register_bank_writer.sv
// Directed bench for register_bank_writer: reset values, single and
// back-to-back writes, write to reg0, the clear sweep, clear/write
// contention and reset during a sweep.
module tb_register_bank_writer;
    import register_bank_writer_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] SP_VAL = 32'h7FFF_FFFC;

    logic              clk;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_addr;
    logic [W-1:0]      wr_data;
    logic              clear_req;
    logic              busy;
    logic              clear_done;
    logic [32*W-1:0]   regs_flat;
    logic [1:0]        dbg_state;

    logic [W-1:0]      exp_regs [32];
    int                n_checks;
    int                n_errors;

    register_bank_writer #(.WORD_LENGTH(W), .SP_INIT(SP_VAL)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .regs_flat  (regs_flat),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, sim not finished");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) exp_regs[k] = '0;
        exp_regs[29] = SP_VAL;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (clear_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", clear_done); end
        n_checks++;
        if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL reset_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_write_single();
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready: got %b want 1", wr_ready); end
        n_checks++;
        if (regs_flat[5*W +: W] !== 32'h0) begin n_errors++; $display("FAIL single_before: got %h want 0", regs_flat[5*W +: W]); end
        tick();
        wr_valid = 1'b0;
        exp_regs[5] = 32'hDEAD_BEEF;
        #1;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL single_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
        tick();
    endtask

    task automatic test_write_zero();
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL zero_ready: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL zero_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
        tick();
    endtask

    task automatic test_clear_sweep();
        for (int k = 1; k < 32; k++) begin
            wr_valid = 1'b1; wr_addr = 5'(k); wr_data = 32'hFFFF_FFFF;
            tick();
            exp_regs[k] = 32'hFFFF_FFFF;
        end
        wr_valid = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL load_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
        clear_req = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL clear_req_ready: got %b want 0", wr_ready); end
        tick();
        clear_req = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            // A second clear_req mid-sweep must not restart it.
            clear_req = (c == 15);
            #1;
            n_checks++;
            if (busy !== 1'b1) begin n_errors++; $display("FAIL sweep_busy c%0d: got %b want 1", c, busy); end
            n_checks++;
            if (clear_done !== (c == 31)) begin n_errors++; $display("FAIL sweep_done c%0d: got %b want %b", c, clear_done, (c == 31)); end
            n_checks++;
            if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL sweep_ready c%0d: got %b want 0", c, wr_ready); end
            if (c == 10 || c == 30) begin
                n_checks++;
                if (regs_flat[c*W +: W] !== 32'hFFFF_FFFF) begin
                    n_errors++;
                    $display("FAIL sweep_unswept c%0d: got %h want ffffffff", c, regs_flat[c*W +: W]);
                end
                n_checks++;
                if (regs_flat[(c-1)*W +: W] !== ((c == 30) ? SP_VAL : 32'h0)) begin
                    n_errors++;
                    $display("FAIL sweep_swept c%0d: got %h want %h", c, regs_flat[(c-1)*W +: W], ((c == 30) ? SP_VAL : 32'h0));
                end
            end
            tick();
        end
        clear_req = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL sweep_end_busy: got %b want 0", busy); end
        n_checks++;
        if (clear_done !== 1'b0) begin n_errors++; $display("FAIL sweep_end_done: got %b want 0", clear_done); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL cleared_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
    endtask

    task automatic test_clear_vs_write();
        clear_req = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333_3333;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL contend_ready: got %b want 0", wr_ready); end
        tick();
        clear_req = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            #1;
            n_checks++;
            if (wr_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL contend_sweep c%0d: ready %b busy %b want 0 1", c, wr_ready, busy);
            end
            n_checks++;
            if (regs_flat[3*W +: W] !== 32'h0) begin
                n_errors++;
                $display("FAIL contend_reg3 c%0d: got %h want 0", c, regs_flat[3*W +: W]);
            end
            tick();
        end
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL contend_after_ready: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        exp_regs[3] = 32'h3333_3333;
        #1;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL contend_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 32'hAAAA_0014; tick();
        wr_addr = 5'd31; wr_data = 32'hBBBB_001F; tick();
        wr_addr = 5'd5;  wr_data = 32'hCCCC_0005; tick();
        wr_valid = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (9) tick();
        #1;
        n_checks++;
        if (dbg_state !== ST_CLEAR) begin n_errors++; $display("FAIL midreset_pre_state: got %0d want %0d", dbg_state, ST_CLEAR); end
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL midreset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL midreset_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
        tick();
        reset = 1'b1;
        tick();
        #1;
        n_checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_after: busy %b ready %b want 0 1", busy, wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [3];
        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h4444_0003;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i + 1); wr_data = vals[i];
            #1;
            n_checks++;
            if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, wr_ready); end
            if (i > 0) begin
                n_checks++;
                if (regs_flat[i*W +: W] !== vals[i-1]) begin
                    n_errors++;
                    $display("FAIL b2b_latency%0d: got %h want %h", i, regs_flat[i*W +: W], vals[i-1]);
                end
            end
            tick();
            exp_regs[i+1] = vals[i];
        end
        wr_valid = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (regs_flat[k*W +: W] !== exp_regs[k]) begin
                n_errors++;
                $display("FAIL b2b_reg%0d: got %h want %h", k, regs_flat[k*W +: W], exp_regs[k]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_write_single();
        test_write_zero();
        test_clear_sweep();
        test_clear_vs_write();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
